srlatch_ctrl: RTL and testbench

Sequencer that owns the s/r inputs of one SR latch and shares it between two requesters. Each set/clear command becomes a timed, mutually exclusive pulse on s or r, followed by a recovery gap. s=r=1 is never driven. The block sits between requester logic and the `_srlatch` instance, and keeps a shadow copy of the latch state.

---
 rtl/srlatch_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 39 +++
 rtl/srlatch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_srlatch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srlatch_ctrl_pkg.sv
// rtl/srlatch_ctrl_pkg.sv - shared encodings for the SR latch sequencer
// Holds the FSM state encoding, set/clear command encoding and the width
// of the shared pulse/gap down-counter.
package srlatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_CLR = 1'b0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with registered last-grant pointer
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (pointer -> last=1, so req[0] wins first tie)
//   req[1:0] in   request vector
//   advance  in   commit the current grant to the pointer
//   gnt[1:0] out  one-hot grant (combinational from req and pointer)
module rr_arb2
  import srlatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Id of the requester granted most recently.
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/srlatch_ctrl.sv
// rtl/srlatch_ctrl.sv - sequencer sharing one SR latch between two requesters
// Optional feature macro: SRLATCH_CTRL_CHECK_EN (q_fb vs shadow state check).
// Parameters:
//   PULSE_CYC  cycles s or r is held per command (1..15)
//   GAP_CYC    cycles of s=r=0 after a pulse or elided command (1..15)
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   req0/cmd0/ack0      requester 0: request, command (1=set, 0=clear), done pulse
//   req1/cmd1/ack1      requester 1: same as requester 0
//   s, r                latch set / reset drives, never both high
//   q_fb                latch q feedback
//   q_exp, q_vld        shadow latch state and its validity
//   busy                sequencer not idle
//   mismatch            sticky feedback error
module srlatch_ctrl
  import srlatch_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic cmd0,
  output logic ack0,
  input  logic req1,
  input  logic cmd1,
  output logic ack1,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic q_exp,
  output logic q_vld,
  output logic busy,
  output logic mismatch
);

  // Counter reload values: the counter runs down to zero, so a phase of
  // N cycles loads N-1 on entry.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gid, gid_n;
  logic             gcmd, gcmd_n;
  logic             s_n, r_n, ack0_n, ack1_n, q_exp_n, q_vld_n, busy_n;

  logic [1:0]       gnt;
  logic             grant_id;
  logic             grant_cmd;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (state == IDLE),
    .gnt     (gnt)
  );

  assign grant_id  = gnt[1];
  assign grant_cmd = gnt[1] ? cmd1 : cmd0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gid_n   = gid;
    gcmd_n  = gcmd;
    s_n     = 1'b0;
    r_n     = 1'b0;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    q_exp_n = q_exp;
    q_vld_n = q_vld;
    busy_n  = 1'b0;

    case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          gid_n  = grant_id;
          gcmd_n = grant_cmd;
          // Latch already in the requested state: acknowledge without pulsing.
          if (q_vld && (grant_cmd == q_exp)) begin
            ack0_n  = ~grant_id;
            ack1_n  = grant_id;
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = PULSE;
            cnt_n   = PULSE_LOAD;
            s_n     = (grant_cmd == CMD_SET);
            r_n     = (grant_cmd == CMD_CLR);
            q_exp_n = grant_cmd;
            q_vld_n = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          ack0_n  = ~gid;
          ack1_n  = gid;
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          s_n   = (gcmd == CMD_SET);
          r_n   = (gcmd == CMD_CLR);
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // Reset leaves the physical latch untouched, so the shadow copy is
  // invalidated rather than assumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      gid   <= 1'b0;
      gcmd  <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      q_exp <= 1'b0;
      q_vld <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gid   <= gid_n;
      gcmd  <= gcmd_n;
      s     <= s_n;
      r     <= r_n;
      ack0  <= ack0_n;
      ack1  <= ack1_n;
      q_exp <= q_exp_n;
      q_vld <= q_vld_n;
      busy  <= busy_n;
    end
  end

`ifdef SRLATCH_CTRL_CHECK_EN
  // Feedback is only trusted while idle, when no pulse is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else if ((state == IDLE) && q_vld && (q_fb != q_exp)) begin
      mismatch <= 1'b1;
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_srlatch_ctrl.sv
// tb/tb_srlatch_ctrl.sv - self-checking bench for srlatch_ctrl
module tb_srlatch_ctrl;

  localparam int P    = 2;
  localparam int G    = 1;
  localparam int NCYC = 4096;
`ifdef SRLATCH_CTRL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic reset;
  logic req0, cmd0, ack0;
  logic req1, cmd1, ack1;
  logic s, r, q_fb, q_exp, q_vld, busy, mismatch;

  srlatch_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .cmd0     (cmd0),
    .ack0     (ack0),
    .req1     (req1),
    .cmd1     (cmd1),
    .ack1     (ack1),
    .s        (s),
    .r        (r),
    .q_fb     (q_fb),
    .q_exp    (q_exp),
    .q_vld    (q_vld),
    .busy     (busy),
    .mismatch (mismatch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Timeline model: a grant books its s/r/ack cycles into per-cycle tables
  // and marks the cycle at which the sequencer is free again.
  bit sch_s  [NCYC];
  bit sch_r  [NCYC];
  bit sch_a0 [NCYC];
  bit sch_a1 [NCYC];
  int cyc         = 0;
  int free_at     = 0;
  bit last        = 1'b1;
  bit model_valid = 1'b0;
  bit m_s, m_r, m_ack0, m_ack1, m_qexp, m_qvld, m_busy, m_mm;

  bit latch   = 1'b0;
  bit corrupt = 1'b0;

  task automatic book_ack(input bit g, input int at);
    if (at < NCYC) begin
      if (g) sch_a1[at] = 1'b1;
      else   sch_a0[at] = 1'b1;
    end
  endtask

  task automatic model_step();
    int t;
    bit g, c, hit;
    t = cyc + 1;
    if (reset) begin
      for (int i = t; i < t + 40 && i < NCYC; i++) begin
        sch_s[i] = 1'b0; sch_r[i] = 1'b0; sch_a0[i] = 1'b0; sch_a1[i] = 1'b0;
      end
      free_at = t; last = 1'b1; m_qexp = 1'b0; m_qvld = 1'b0; m_mm = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      hit = CHK && (t - 1 >= free_at) && m_qvld && (q_fb != m_qexp);
      if ((t - 1 >= free_at) && (req0 || req1)) begin
        g = (req0 && req1) ? !last : req1;
        c = g ? cmd1 : cmd0;
        last = g;
        if (m_qvld && (c == m_qexp)) begin
          book_ack(g, t);
          free_at = t + G;
        end else begin
          for (int k = 0; k < P; k++) begin
            if (t + k < NCYC) begin
              sch_s[t + k] = c;
              sch_r[t + k] = !c;
            end
          end
          book_ack(g, t + P);
          free_at = t + P + G;
          m_qexp = c;
          m_qvld = 1'b1;
        end
      end
      if (hit) m_mm = 1'b1;
    end
    if (t < NCYC) begin
      m_s = sch_s[t]; m_r = sch_r[t]; m_ack0 = sch_a0[t]; m_ack1 = sch_a1[t];
    end
    m_busy = (t < free_at);
    cyc = t;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [7:0] act, exp;
    @(negedge clk);
    if (model_valid) begin
      act = {s, r, ack0, ack1, q_exp, q_vld, busy, mismatch};
      exp = {m_s, m_r, m_ack0, m_ack1, m_qexp, m_qvld, m_busy, m_mm};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL outputs cyc=%0d act=%b exp=%b (s r ack0 ack1 q_exp q_vld busy mismatch)", cyc, act, exp);
      end
      checks++;
      if (s === 1'b1 && r === 1'b1) begin
        failures++;
        $display("FAIL s_and_r cyc=%0d act s=%b r=%b exp not both 1", cyc, s, r);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (m_ack0) req0 = 1'b0;
    if (m_ack1) req1 = 1'b0;
    if (m_s) latch = 1'b1;
    if (m_r) latch = 1'b0;
    q_fb = latch ^ corrupt;
  endtask

  task automatic lit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (m_busy && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (m_busy) begin
      failures++;
      $display("FAIL %s timeout cyc=%0d act busy=1 exp busy=0", nm, cyc);
    end
  endtask

  task automatic wait_ack0(input string nm);
    int n;
    n = 0;
    while (!m_ack0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!m_ack0) begin
      failures++;
      $display("FAIL %s timeout cyc=%0d act ack0=0 exp ack0=1", nm, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int k, n;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = 1'b0; cmd1 = 1'b0; q_fb = 1'b0;
    repeat (3) tick();
    lit("rst_s", s, 1'b0);
    lit("rst_q_vld", q_vld, 1'b0);
    lit("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Set from reset: s for two cycles, ack on the third.
    req0 = 1'b1; cmd0 = 1'b1;
    tick();
    lit("d1_s_t1", s, 1'b1); lit("d1_r_t1", r, 1'b0); lit("d1_busy_t1", busy, 1'b1);
    lit("d1_model_s_t1", m_s, 1'b1);
    tick();
    lit("d1_s_t2", s, 1'b1); lit("d1_ack0_t2", ack0, 1'b0);
    tick();
    lit("d1_s_t3", s, 1'b0); lit("d1_ack0_t3", ack0, 1'b1);
    lit("d1_q_exp", q_exp, 1'b1); lit("d1_q_vld", q_vld, 1'b1);
    lit("d1_model_ack0_t3", m_ack0, 1'b1);
    tick();
    lit("d1_busy_t4", busy, 1'b0); lit("d1_ack0_t4", ack0, 1'b0);

    // Simultaneous requests after reset: requester 0 first, then 1.
    do_reset();
    req0 = 1'b1; cmd0 = 1'b0; req1 = 1'b1; cmd1 = 1'b1;
    tick();
    lit("d2_r_t1", r, 1'b1); lit("d2_s_t1", s, 1'b0);
    tick(); tick();
    lit("d2_ack0_t3", ack0, 1'b1); lit("d2_ack1_t3", ack1, 1'b0);
    tick(); tick();
    lit("d2_s_t5", s, 1'b1); lit("d2_r_t5", r, 1'b0);
    tick(); tick();
    lit("d2_ack1_t7", ack1, 1'b1); lit("d2_q_exp_t7", q_exp, 1'b1);

    // Redundant set from requester 1 is elided.
    wait_idle("d3_idle");
    req1 = 1'b1; cmd1 = 1'b1;
    tick();
    lit("d3_ack1_t1", ack1, 1'b1); lit("d3_s_t1", s, 1'b0); lit("d3_r_t1", r, 1'b0);
    lit("d3_busy_t1", busy, 1'b1); lit("d3_model_ack1_t1", m_ack1, 1'b1);
    tick();
    lit("d3_busy_t2", busy, 1'b0); lit("d3_ack1_t2", ack1, 1'b0);

    // Reset during the second pulse cycle of a set.
    req0 = 1'b1; cmd0 = 1'b0;
    wait_ack0("d4_clr_ack");
    wait_idle("d4_clr_idle");
    req0 = 1'b1; cmd0 = 1'b1;
    tick();
    lit("d4_s_t1", s, 1'b1);
    tick();
    lit("d4_s_t2", s, 1'b1);
    reset = 1'b1; req0 = 1'b0;
    tick();
    lit("d4_s_after_rst", s, 1'b0); lit("d4_ack0_after_rst", ack0, 1'b0);
    lit("d4_q_vld_after_rst", q_vld, 1'b0); lit("d4_busy_after_rst", busy, 1'b0);
    reset = 1'b0;
    tick();
    lit("d4_no_late_ack", ack0, 1'b0);
    req0 = 1'b1; cmd0 = 1'b1;
    tick();
    lit("d4_set_not_elided", s, 1'b1); lit("d4_model_set_not_elided", m_s, 1'b1);
    wait_ack0("d4_set_ack");
    wait_idle("d4_set_idle");

    // Feedback disagreement while idle with a valid shadow.
    corrupt = 1'b1; q_fb = latch ^ corrupt;
    tick();
    lit("d6_mismatch_t1", mismatch, CHK);
    tick();
    lit("d6_mismatch_t2", mismatch, CHK);
    corrupt = 1'b0; q_fb = latch;
    tick();
    lit("d6_mismatch_sticky", mismatch, CHK);
    reset = 1'b1;
    tick();
    lit("d6_mismatch_rst", mismatch, 1'b0);
    reset = 1'b0;
    tick();

    // Continuous requests from both: grants alternate 0,1,0,1...
    do_reset();
    req0 = 1'b1; cmd0 = 1'b1; req1 = 1'b1; cmd1 = 1'b0;
    k = 0; n = 0;
    while (k < 10 && n < 200) begin
      tick();
      n++;
      if (ack0 || ack1) begin
        lit("d5_ack1_order", ack1, (k % 2) == 1);
        lit("d5_ack0_order", ack0, (k % 2) == 0);
        k++;
      end
      if (m_ack0) begin req0 = 1'b1; cmd0 = !cmd0; end
      if (m_ack1) begin req1 = 1'b1; cmd1 = !cmd1; end
    end
    checks++;
    if (k != 10) begin
      failures++;
      $display("FAIL d5_ack_count act=%0d exp=10", k);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    wait_idle("d5_idle");

    // Randomised traffic, occasional resets and feedback corruption.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      end
      if (!reset) begin
        if (!req0 && $urandom_range(0, 2) == 0) begin
          req0 = 1'b1; cmd0 = 1'($urandom_range(0, 1));
        end
        if (!req1 && $urandom_range(0, 2) == 0) begin
          req1 = 1'b1; cmd1 = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        corrupt = !corrupt;
        q_fb = latch ^ corrupt;
      end
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    wait_idle("rand_idle");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
